// File: rtl/oh_pwr_seq_pkg.sv
// rtl/oh_pwr_seq_pkg.sv - power sequencer state encodings and constant helpers
package oh_pwr_seq_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] S_OFF     = 4'd0;
  localparam logic [ST_W-1:0] S_REQ     = 4'd1;
  localparam logic [ST_W-1:0] S_RAMP    = 4'd2;
  localparam logic [ST_W-1:0] S_SETTLE  = 4'd3;
  localparam logic [ST_W-1:0] S_RESTORE = 4'd4;
  localparam logic [ST_W-1:0] S_RELRST  = 4'd5;
  localparam logic [ST_W-1:0] S_ON      = 4'd6;
  localparam logic [ST_W-1:0] S_ISO     = 4'd7;
  localparam logic [ST_W-1:0] S_SAVE    = 4'd8;
  localparam logic [ST_W-1:0] S_RSTA    = 4'd9;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oh_pwr_seq_ch.sv
// rtl/oh_pwr_seq_ch.sv - per-domain power-up/down sequencer with ramp/settle counter
module oh_pwr_seq_ch
  import oh_pwr_seq_pkg::*;
#(
  parameter int SEGS          = 4,
  parameter int RAMP_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            req_on,
  input  logic            grant,
  output logic            req,
  output logic            holding,
  output logic [SEGS-1:0] npower,
  output logic            iso,
  output logic            ret_save,
  output logic            ret_restore,
  output logic            dom_nreset,
  output logic            on,
  output logic            busy
);

  localparam int RAMP_LEN = SEGS * RAMP_CYCLES;
  localparam int CNT_W    = clog2(max_int(RAMP_LEN, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      case (state)
        S_OFF:     if (req_on) state <= S_REQ;
        S_REQ: begin
          if (grant) begin
            state <= S_RAMP;
            cnt   <= '0;
          end
        end
        S_RAMP: begin
          if (cnt == RAMP_LAST) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_RESTORE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESTORE: state <= S_RELRST;
        S_RELRST:  state <= S_ON;
        S_ON:      if (!req_on) state <= S_ISO;
        S_ISO:     state <= S_SAVE;
        S_SAVE:    state <= S_RSTA;
        S_RSTA:    state <= S_OFF;
        default:   state <= S_OFF;
      endcase
    end
  end

  // Segment j closes once the ramp counter passes j*RAMP_CYCLES; all open together on reaching OFF.
  always_comb begin
    npower = '1;
    if (state == S_RAMP) begin
      for (int j = 0; j < SEGS; j++) begin
        npower[j] = !(32'(cnt) >= $unsigned(j * RAMP_CYCLES));
      end
    end else if (state != S_OFF && state != S_REQ) begin
      npower = '0;
    end
  end

  assign req         = (state == S_REQ);
  assign holding     = (state == S_RAMP) || (state == S_SETTLE);
  assign iso         = (state != S_ON);
  assign ret_save    = (state == S_SAVE);
  assign ret_restore = (state == S_RESTORE);
  assign dom_nreset  = (state == S_RELRST) || (state == S_ON) ||
                       (state == S_ISO) || (state == S_SAVE);
  assign on          = (state == S_ON);
  assign busy        = (state != S_OFF) && (state != S_ON);

endmodule

// File: rtl/oh_pwr_seq.sv
// rtl/oh_pwr_seq.sv - N-domain power-gating sequencer with one-at-a-time ramp arbitration
module oh_pwr_seq
  import oh_pwr_seq_pkg::*;
#(
  parameter int N             = 2,
  parameter int SEGS          = 4,
  parameter int RAMP_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [N-1:0]      req_on,
  output logic [N*SEGS-1:0] npower,
  output logic [N-1:0]      iso,
  output logic [N-1:0]      ret_save,
  output logic [N-1:0]      ret_restore,
  output logic [N-1:0]      dom_nreset,
  output logic [N-1:0]      on,
  output logic [N-1:0]      busy
);

  logic [N-1:0] req;
  logic [N-1:0] holding;
  logic [N-1:0] grant;

  // Only power-up ramps compete; a new grant waits until the current holder leaves SETTLE.
  always_comb begin
    grant = '0;
    if (!(|holding)) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    oh_pwr_seq_ch #(
      .SEGS          (SEGS),
      .RAMP_CYCLES   (RAMP_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .nreset      (nreset),
      .req_on      (req_on[i]),
      .grant       (grant[i]),
      .req         (req[i]),
      .holding     (holding[i]),
      .npower      (npower[i*SEGS +: SEGS]),
      .iso         (iso[i]),
      .ret_save    (ret_save[i]),
      .ret_restore (ret_restore[i]),
      .dom_nreset  (dom_nreset[i]),
      .on          (on[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_oh_pwr_seq.sv
// tb/tb_oh_pwr_seq.sv - self-checking bench for oh_pwr_seq with a timeline model
module tb_oh_pwr_seq;

  localparam int N    = 2;
  localparam int SEGS = 4;
  localparam int RC   = 8;
  localparam int ST   = 16;
  localparam int SR   = SEGS * RC;

  localparam int P_OFF  = 0;
  localparam int P_WAIT = 1;
  localparam int P_UP   = 2;
  localparam int P_ON   = 3;
  localparam int P_DOWN = 4;

  logic              clk = 1'b0;
  logic              nreset;
  logic [N-1:0]      req_on;
  logic [N*SEGS-1:0] npower;
  logic [N-1:0]      iso, ret_save, ret_restore, dom_nreset, on, busy;

  oh_pwr_seq #(.N(N), .SEGS(SEGS), .RAMP_CYCLES(RC), .SETTLE_CYCLES(ST)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req_on      (req_on),
    .npower      (npower),
    .iso         (iso),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .dom_nreset  (dom_nreset),
    .on          (on),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ph[N];
  int t0[N];
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Model: each domain is a phase plus the edge at which its current sequence started.
  always @(negedge nreset) begin
    for (int i = 0; i < N; i++) ph[i] = P_OFF;
  end

  always @(posedge clk) begin : model
    int  win;
    bit  held;
    int  e;
    if (!nreset) begin
      for (int i = 0; i < N; i++) ph[i] = P_OFF;
    end else begin
      held = 1'b0;
      win  = -1;
      for (int i = 0; i < N; i++)
        if (ph[i] == P_UP && (cyc - t0[i]) < SR + ST) held = 1'b1;
      if (!held)
        for (int i = N - 1; i >= 0; i--)
          if (ph[i] == P_WAIT) win = i;
      for (int i = 0; i < N; i++) begin
        e = cyc - t0[i];
        case (ph[i])
          P_OFF:  if (req_on[i]) ph[i] = P_WAIT;
          P_WAIT: if (win == i) begin ph[i] = P_UP; t0[i] = cyc + 1; end
          P_UP:   if (e == SR + ST + 1) ph[i] = P_ON;
          P_ON:   if (!req_on[i]) begin ph[i] = P_DOWN; t0[i] = cyc + 1; end
          P_DOWN: if (e == 2) ph[i] = P_OFF;
          default: ph[i] = P_OFF;
        endcase
      end
    end
    cyc = cyc + 1;
  end

  // Expected {npower slice, iso, ret_save, ret_restore, dom_nreset, on, busy} for one domain.
  function automatic logic [SEGS+5:0] exp_dom(input int p, input int e);
    logic [SEGS-1:0] np;
    logic i_e, sv, rs, dn, o, b;
    np = '1; i_e = 1'b1; sv = 1'b0; rs = 1'b0; dn = 1'b0; o = 1'b0; b = 1'b0;
    case (p)
      P_WAIT: b = 1'b1;
      P_UP: begin
        b = 1'b1;
        if (e < SR) begin
          for (int j = 0; j < SEGS; j++) np[j] = !(e >= j * RC);
        end else begin
          np = '0;
        end
        rs = (e == SR + ST);
        dn = (e == SR + ST + 1);
      end
      P_ON: begin
        np = '0; i_e = 1'b0; dn = 1'b1; o = 1'b1;
      end
      P_DOWN: begin
        np = '0; b = 1'b1; sv = (e == 1); dn = (e < 2);
      end
      default: ;
    endcase
    return {np, i_e, sv, rs, dn, o, b};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_dom%0d", i),
              {npower[i*SEGS +: SEGS], iso[i], ret_save[i], ret_restore[i],
               dom_nreset[i], on[i], busy[i]},
              exp_dom(ph[i], cyc - t0[i]));
      end
    end
  end

  initial begin : stim
    int s;
    nreset = 1'b0;
    req_on = N'($urandom);
    repeat (3) @(negedge clk);
    check("rst_npower", npower, 8'hFF);
    check("rst_iso", iso, 2'b11);
    check("rst_dom_nreset", dom_nreset, 2'b00);
    check("rst_on_busy", {on, busy, ret_save, ret_restore}, 8'h00);
    chk_en = 1'b1;
    req_on = '0;
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // single power-up of domain 0
    req_on = 2'b01;
    s = cyc + 1;
    wait_to(s + 1);  check("up_seg0", npower[3:0], 4'b1110);
    wait_to(s + 9);  check("up_seg1", npower[3:0], 4'b1100);
    wait_to(s + 25); check("up_seg3", npower[3:0], 4'b0000);
    wait_to(s + 49); check("up_restore", ret_restore[0], 1'b1);
    wait_to(s + 50); check("up_relrst", {dom_nreset[0], iso[0], on[0]}, 3'b110);
    wait_to(s + 51); check("up_on", {iso[0], on[0]}, 2'b01);
    repeat (3) @(negedge clk);

    // power-down of domain 0
    req_on = 2'b00;
    s = cyc + 1;
    wait_to(s);     check("dn_iso", {iso[0], on[0]}, 2'b10);
    wait_to(s + 1); check("dn_save", ret_save[0], 1'b1);
    wait_to(s + 2); check("dn_rsta", {dom_nreset[0], npower[3:0]}, 5'b00000);
    wait_to(s + 3); check("dn_off", {npower[3:0], busy[0]}, 5'b11110);
    repeat (2) @(negedge clk);

    // contention: both request in the same cycle
    req_on = 2'b11;
    s = cyc + 1;
    wait_to(s + 49);  check("ct_d1_wait", npower[7:4], 4'hF);
    wait_to(s + 50);  check("ct_d1_ramp", npower[7:4], 4'b1110);
    wait_to(s + 51);  check("ct_on0", on, 2'b01);
    wait_to(s + 99);  check("ct_on1_early", on, 2'b01);
    wait_to(s + 100); check("ct_on1", on, 2'b11);
    req_on = 2'b00;
    repeat (6) @(negedge clk);

    // request dropped mid-ramp: power-up completes, then powers down
    req_on = 2'b01;
    s = cyc + 1;
    wait_to(s + 10);
    req_on = 2'b00;
    wait_to(s + 51); check("tg_on", on[0], 1'b1);
    wait_to(s + 52); check("tg_iso", {on[0], iso[0]}, 2'b01);
    wait_to(s + 56);

    // asynchronous reset mid-ramp of domain 1
    req_on = 2'b10;
    s = cyc + 1;
    wait_to(s + 5);
    check("ar_pre", npower[7:4], 4'b1110);
    #2 nreset = 1'b0;
    #1;
    check("ar_npower", npower, 8'hFF);
    check("ar_iso", iso, 2'b11);
    check("ar_rest", {on, busy, dom_nreset}, 6'b0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    s = cyc + 1;
    wait_to(s + 50); check("ar_restart_pre", on, 2'b00);
    wait_to(s + 51); check("ar_restart_on", on, 2'b10);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
